imem_loader: RTL and testbench



---
 rtl/cpu_pkg.sv | 28 ++
 rtl/imem_ram.sv | 47 ++++
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction memory and the loader:
//   - opcode constants OP_HALT / OP_NOP
//   - HALT_WORD, the all-zero instruction that stops the processor and
//     also terminates a byte-serial load
//   - instr_t, the 16-bit instruction word type
//   - ld_state_t, the loader FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0]  OP_HALT   = 4'h0;
   localparam logic [3:0]  OP_NOP    = 4'hF;
   localparam logic [15:0] HALT_WORD = 16'h0000;

   typedef logic [15:0] instr_t;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      WR,
      CK,
      DONE
   } ld_state_t;

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// DEPTH x 16 instruction storage with one synchronous write port and one
// combinational read port. Reads beyond DEPTH return HALT_WORD so a runaway
// PC stops the processor instead of aliasing back into the program.
// Ports:
//   clk    in   system clock
//   we     in   write enable (write happens on the rising edge)
//   waddr  in   AW-bit write address
//   wdata  in   16-bit write data
//   raddr  in   8-bit fetch address
//   rdata  out  16-bit instruction at raddr (HALT_WORD when out of range)
// ---------------------------------------------------------------------------
module imem_ram
   import cpu_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  instr_t        wdata,
   input  logic [7:0]    raddr,
   output instr_t        rdata
);

   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   // Contents are not touched by reset; the declaration initialiser gives
   // the all-HALT power-up image.
   instr_t mem [DEPTH] = '{default: HALT_WORD};

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = HALT_WORD;
      if ({1'b0, raddr} < DEPTH_W) begin
         rdata = mem[raddr[AW-1:0]];
      end
   end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writable instruction memory with a byte-serial loader. Bytes arrive over a
// valid/ready handshake, are paired big-endian into words and written from
// address 0 upward. A HALT word ends the load normally; filling the memory
// without a HALT ends it with an error. While loading (or after a failed
// load) cpu_hold keeps the processor in reset and the fetch port reads HALT.
// Optional feature (macro IMEM_CHECKSUM_EN): after the HALT word one extra
// byte is accepted and compared against the XOR of all data bytes.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ld_start         pulse, begin a load from address 0
//   ld_byte/ld_valid load byte and its valid flag
//   ld_ready         loader accepts a byte this cycle
//   ld_done          last load finished
//   ld_err           last load terminated abnormally
//   cpu_hold         processor reset request
//   words_loaded     words written by the current/last load
//   pc / instr       combinational fetch port
// ---------------------------------------------------------------------------
module imem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_start,
   input  logic [7:0]    ld_byte,
   input  logic          ld_valid,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          ld_err,
   output logic          cpu_hold,
   output logic [AW:0]   words_loaded,
   input  logic [7:0]    pc,
   output instr_t        instr
);

   ld_state_t     state_q, state_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    lo_q, lo_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   words_loaded_q, words_loaded_d;
   logic          ld_ready_q, ld_ready_d;
   logic          ld_err_q, ld_err_d;
`ifdef IMEM_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   logic   accept;
   logic   ram_we;
   instr_t wr_word;
   instr_t ram_rdata;
   logic   mem_full;

   assign accept   = ld_valid & ld_ready_q;
   assign wr_word  = {hi_q, lo_q};
   assign mem_full = (wptr_q == AW'(DEPTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         hi_q           <= '0;
         lo_q           <= '0;
         wptr_q         <= '0;
         words_loaded_q <= '0;
         ld_ready_q     <= 1'b0;
         ld_err_q       <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
         csum_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         wptr_q         <= wptr_d;
         words_loaded_q <= words_loaded_d;
         ld_ready_q     <= ld_ready_d;
         ld_err_q       <= ld_err_d;
`ifdef IMEM_CHECKSUM_EN
         csum_q         <= csum_d;
`endif
      end
   end

   // Next-state logic; ld_start in DONE wins over any offered byte because
   // ld_ready is low there, so no byte can be consumed in that cycle.
   always_comb begin
      state_d        = state_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      wptr_d         = wptr_q;
      words_loaded_d = words_loaded_q;
      ld_err_d       = ld_err_q;
`ifdef IMEM_CHECKSUM_EN
      csum_d         = csum_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (ld_start) begin
               state_d        = HI;
               wptr_d         = '0;
               words_loaded_d = '0;
               ld_err_d       = 1'b0;
`ifdef IMEM_CHECKSUM_EN
               csum_d         = '0;
`endif
            end
         end
         HI: begin
            if (accept) begin
               hi_d    = ld_byte;
               state_d = LO;
`ifdef IMEM_CHECKSUM_EN
               csum_d  = csum_q ^ ld_byte;
`endif
            end
         end
         LO: begin
            if (accept) begin
               lo_d    = ld_byte;
               state_d = WR;
`ifdef IMEM_CHECKSUM_EN
               csum_d  = csum_q ^ ld_byte;
`endif
            end
         end
         WR: begin
            // The pointer is frozen on the last slot so it can never wrap.
            if (!mem_full) begin
               wptr_d = wptr_q + 1'b1;
            end
            if (words_loaded_q != (AW+1)'(DEPTH)) begin
               words_loaded_d = words_loaded_q + 1'b1;
            end
            if (wr_word == HALT_WORD) begin
`ifdef IMEM_CHECKSUM_EN
               state_d  = CK;
`else
               state_d  = DONE;
               ld_err_d = 1'b0;
`endif
            end else if (mem_full) begin
               state_d  = DONE;
               ld_err_d = 1'b1;
            end else begin
               state_d  = HI;
            end
         end
`ifdef IMEM_CHECKSUM_EN
         CK: begin
            if (accept) begin
               state_d  = DONE;
               ld_err_d = (ld_byte != csum_q);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      ld_ready_d = (state_d == HI) || (state_d == LO) || (state_d == CK);
   end

   // Output logic
   always_comb begin
      ld_done  = (state_q == DONE);
      ram_we   = (state_q == WR);
      cpu_hold = (state_q == HI) || (state_q == LO) || (state_q == WR) ||
                 (state_q == CK) || ((state_q == DONE) && ld_err_q);
   end

   assign ld_ready     = ld_ready_q;
   assign ld_err       = ld_err_q;
   assign words_loaded = words_loaded_q;
   assign instr        = cpu_hold ? HALT_WORD : ram_rdata;

   imem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr_q),
      .wdata (wr_word),
      .raddr (pc),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: fetch-port reads are table driven,
// the loads and the reset/overflow corners are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_start;
   logic [7:0]    ld_byte;
   logic          ld_valid;
   logic          ld_ready;
   logic          ld_done;
   logic          ld_err;
   logic          cpu_hold;
   logic [AW:0]   words_loaded;
   logic [7:0]    pc;
   logic [15:0]   instr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] exp_instr;
   } rd_vec_t;

   rd_vec_t    tbl[$];
   logic [7:0] stream[$];

   // Per-cycle observation of a load with ld_valid held high
   logic mon_en = 1'b0;
   int   mon_cycles = 0;
   int   rdy_low = 0;
   int   hold_low = 0;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_start     (ld_start),
      .ld_byte      (ld_byte),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_done      (ld_done),
      .ld_err       (ld_err),
      .cpu_hold     (cpu_hold),
      .words_loaded (words_loaded),
      .pc           (pc),
      .instr        (instr)
   );

   always #5 clk = ~clk;

   // Counts the cycles from the first HI cycle until DONE is reached
   always @(negedge clk) begin
      if (mon_en && !ld_done) begin
         mon_cycles++;
         if (!ld_ready) rdy_low++;
         if (!cpu_hold) hold_low++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] p);
      step();
      pc = p;
      #2;
   endtask

   task automatic run_table();
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].pc);
         checkOutput($sformatf("instr@%0d", tbl[i].pc), 32'(instr), 32'(tbl[i].exp_instr));
      end
      tbl.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            ld_valid = 1'b0;
            ld_byte  = 8'($urandom);
            step();
         end
      end
      ld_byte  = b;
      ld_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ld_ready) begin
            ok = 1;
            step();
            break;
         end
      end
      ld_valid = 1'b0;
      if (!ok) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   task automatic send_stream(input bit gaps);
      foreach (stream[i]) send_byte(stream[i], gaps);
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ld_done) begin
            ok = 1;
            break;
         end
      end
      step();
      if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [7:0] stream_xor();
      logic [7:0] x = 8'h00;
      foreach (stream[i]) x ^= stream[i];
      return x;
   endfunction

   // Appends the checksum byte when the checksum stage is built in
   task automatic add_csum();
`ifdef IMEM_CHECKSUM_EN
      logic [7:0] c = stream_xor();
      stream.push_back(c);
`endif
   endtask

   task automatic set_prog_a();
      stream = '{8'h10, 8'h00, 8'h10, 8'h11, 8'hE2, 8'h36, 8'h00, 8'h00};
      add_csum();
   endtask

   initial begin
      int exp_cycles;
      reset    = 1'b1;
      ld_start = 1'b0;
      ld_byte  = 8'h00;
      ld_valid = 1'b0;
      pc       = 8'h00;
      step();
      step();
      reset = 1'b0;

      // Reset state and power-up image
      checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("reset_ld_ready", 32'(ld_ready), 32'd0);
      checkOutput("reset_ld_done", 32'(ld_done), 32'd0);
      checkOutput("reset_ld_err", 32'(ld_err), 32'd0);
      checkOutput("reset_words", 32'(words_loaded), 32'd0);
      for (int p = 0; p <= 40; p++) tbl.push_back('{8'(p), 16'h0000});
      run_table();

      // Back-to-back load with ld_valid held high
      $display("[TB] load with continuous valid");
      set_prog_a();
      checkOutput("idle_cpu_hold", 32'(cpu_hold), 32'd0);
      start_load();
      mon_en = 1'b1;
      send_stream(1'b0);
      wait_done();
      mon_en = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      exp_cycles = 13;
`else
      exp_cycles = 12;
`endif
      checkOutput("load_cycles", 32'(mon_cycles), 32'(exp_cycles));
      checkOutput("ready_low_cycles", 32'(rdy_low), 32'd4);
      checkOutput("hold_low_cycles", 32'(hold_low), 32'd0);
      checkOutput("a_words", 32'(words_loaded), 32'd4);
      checkOutput("a_done", 32'(ld_done), 32'd1);
      checkOutput("a_err", 32'(ld_err), 32'd0);
      checkOutput("a_hold", 32'(cpu_hold), 32'd0);
      checkOutput("a_ready_done", 32'(ld_ready), 32'd0);
      tbl = '{'{8'd0, 16'h1000}, '{8'd1, 16'h1011}, '{8'd2, 16'hE236},
              '{8'd3, 16'h0000}, '{8'd4, 16'h0000}, '{8'd31, 16'h0000}};
      run_table();

      // Overwrite with another image, then reload program A with gaps
      stream = '{8'hAB, 8'hCD, 8'h00, 8'h00};
      add_csum();
      start_load();
      send_stream(1'b0);
      wait_done();
      tbl = '{'{8'd0, 16'hABCD}, '{8'd1, 16'h0000}};
      run_table();

      $display("[TB] load with random valid gaps");
      set_prog_a();
      start_load();
      send_stream(1'b1);
      wait_done();
      checkOutput("gap_words", 32'(words_loaded), 32'd4);
      checkOutput("gap_err", 32'(ld_err), 32'd0);
      tbl = '{'{8'd0, 16'h1000}, '{8'd1, 16'h1011}, '{8'd2, 16'hE236},
              '{8'd3, 16'h0000}};
      run_table();

      // Fill every slot without a HALT word
      $display("[TB] overflow load");
      stream.delete();
      for (int i = 0; i < DEPTH; i++) begin
         stream.push_back(8'(i + 1));
         stream.push_back(8'hA5);
      end
      start_load();
      send_stream(1'b0);
      wait_done();
      checkOutput("full_done", 32'(ld_done), 32'd1);
      checkOutput("full_err", 32'(ld_err), 32'd1);
      checkOutput("full_hold", 32'(cpu_hold), 32'd1);
      checkOutput("full_words", 32'(words_loaded), 32'(DEPTH));
      tbl = '{'{8'd1, 16'h0000}};
      run_table();

      // A HALT-only reload recovers
      stream = '{8'h00, 8'h00};
      add_csum();
      start_load();
      send_stream(1'b0);
      wait_done();
      checkOutput("recover_err", 32'(ld_err), 32'd0);
      checkOutput("recover_hold", 32'(cpu_hold), 32'd0);
      checkOutput("recover_words", 32'(words_loaded), 32'd1);
      tbl = '{'{8'd0, 16'h0000}, '{8'd1, 16'h02A5}, '{8'd30, 16'h1FA5},
              '{8'd31, 16'h20A5}, '{8'd32, 16'h0000}, '{8'd255, 16'h0000}};
      run_table();

      // Reset in the middle of a load
      $display("[TB] reset mid-load");
      start_load();
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("mid_reset_hold", 32'(cpu_hold), 32'd0);
      checkOutput("mid_reset_words", 32'(words_loaded), 32'd0);
      checkOutput("mid_reset_ready", 32'(ld_ready), 32'd0);
      checkOutput("mid_reset_done", 32'(ld_done), 32'd0);
      tbl = '{'{8'd0, 16'h1234}, '{8'd1, 16'h02A5}};
      run_table();

`ifdef IMEM_CHECKSUM_EN
      $display("[TB] checksum checks");
      stream = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h10};
      start_load();
      send_stream(1'b0);
      wait_done();
      checkOutput("ck_good_err", 32'(ld_err), 32'd0);
      checkOutput("ck_good_hold", 32'(cpu_hold), 32'd0);
      stream = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h11};
      start_load();
      send_stream(1'b0);
      wait_done();
      checkOutput("ck_bad_err", 32'(ld_err), 32'd1);
      checkOutput("ck_bad_hold", 32'(cpu_hold), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
